// File: rtl/tpmem_row_feeder.sv
// Writer-side front end for the 16x16 transpose memory: packs 256 serial samples into 16 row
// words, bursts them out, then guards 16 cycles. Optional short-frame padding via TPFEED_PAD_EN.
module tpmem_row_feeder #(
    parameter int BW = 11
) (
    input  logic               i_clk,
    input  logic               i_Reset,
    input  logic [BW-1:0]      i_data,
    input  logic               i_valid,
`ifdef TPFEED_PAD_EN
    input  logic               i_last,
`endif
    output logic               o_ready,
    output logic [16*BW-1:0]   o_data,
    output logic               o_enable,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_SEND  = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_cnt;
    logic [3:0]          r_row;
    logic [3:0]          r_guard;
    logic [BW-1:0]       r_buf [0:255];
    logic [16*BW-1:0]    r_data_p1;
    logic                r_vld_p1;
    logic [16*BW-1:0]    w_row;
    logic                w_accept;
    logic                w_frame_end;
    logic [7:0]          w_last_idx;

    // A slot is live when its frame index does not exceed the final accepted index.
    function automatic logic slot_live(input logic [7:0] idx, input logic [7:0] last_idx);
        return idx <= last_idx;
    endfunction

    assign w_accept = i_valid && o_ready;

`ifdef TPFEED_PAD_EN
    logic [7:0] r_last_idx;

    assign w_frame_end = w_accept && ((r_cnt == 8'hFF) || i_last);
    assign w_last_idx  = r_last_idx;

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            r_last_idx <= 8'hFF;
        end else if (w_frame_end) begin
            r_last_idx <= r_cnt;
        end
    end
`else
    assign w_frame_end = w_accept && (r_cnt == 8'hFF);
    assign w_last_idx  = 8'hFF;
`endif

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_busy  = 1'b0;
        case (r_state)
            S_FILL: begin
                o_ready = !i_Reset;
                if (w_frame_end) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                o_busy = !i_Reset;
                if (r_row == 4'd15) begin
                    w_next = S_GUARD;
                end
            end
            S_GUARD: begin
                o_busy = !i_Reset;
                if (r_guard == 4'd15) begin
                    w_next = S_FILL;
                end
            end
            default: begin
                w_next = S_FILL;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            r_cnt   <= 8'd0;
            r_row   <= 4'd0;
            r_guard <= 4'd0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_frame_end) begin
                        r_cnt <= 8'd0;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SEND: begin
                    r_row <= r_row + 4'd1;
                end
                S_GUARD: begin
                    r_guard <= r_guard + 4'd1;
                    if (r_guard == 4'd15) begin
                        r_cnt <= 8'd0;
                    end
                end
                default: begin
                    r_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Frame buffer holds data only; it is never reset, every live slot is rewritten per frame.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buf[r_cnt] <= i_data;
        end
    end

    // Slot 0 sits in the most significant field of the row word.
    always_comb begin
        w_row = '0;
        for (int j = 0; j < 16; j++) begin
            if (slot_live({r_row, 4'(j)}, w_last_idx)) begin
                w_row[(15-j)*BW +: BW] = r_buf[{r_row, 4'(j)}];
            end
        end
    end

    // Output stage p1: one registered row per SEND cycle, zeros otherwise.
    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end else if (r_state == S_SEND) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= w_row;
        end else begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end
    end

    assign o_data   = r_data_p1;
    assign o_enable = r_vld_p1;

endmodule

// File: tb/tb_tpmem_row_feeder.sv
// Scoreboard bench for tpmem_row_feeder: expected rows are queued as samples are accepted
// and popped as the burst appears. Build with TPFEED_PAD_EN to add the short-frame scenario.
module tb_tpmem_row_feeder;
    localparam int BW = 11;
    localparam int RW = 16 * BW;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] i_data;
    logic          i_valid;
    logic          i_last;
    logic          o_ready;
    logic [RW-1:0] o_data;
    logic          o_enable;
    logic          o_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_en_cyc = 0;
    int last_en_cyc  = 0;

    logic [RW-1:0] exp_q[$];
    logic [BW-1:0] m_buf [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    tpmem_row_feeder #(.BW(BW)) dut (
        .i_clk    (clk),
        .i_Reset  (rst),
        .i_data   (i_data),
        .i_valid  (i_valid),
`ifdef TPFEED_PAD_EN
        .i_last   (i_last),
`endif
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_enable (o_enable),
        .o_busy   (o_busy)
    );

    // kind < 0: counting sample value n, otherwise a constant value
    function automatic logic [BW-1:0] pat(input int kind, input int n);
        if (kind < 0) return BW'(n);
        return BW'(kind);
    endfunction

    task automatic send_frame(input int kind, input bit toggle, input int last_at);
        int idx = 0;
        int k = 0;
        bit done = 0;
        logic [RW-1:0] w;
        while (!done && k < 5000) begin
            @(negedge clk);
            k++;
            i_valid = (toggle && (k % 2 == 0)) ? 1'b0 : 1'b1;
            i_data  = i_valid ? pat(kind, idx) : BW'(2047);
            i_last  = i_valid && (idx == last_at);
            if (i_valid && o_ready) begin
                m_buf[idx] = i_data;
                if (idx == 255 || idx == last_at) done = 1;
                else idx++;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL send_timeout accepted=%0d required=256", idx);
        end
        for (int r = 0; r < 16; r++) begin
            w = '0;
            for (int j = 0; j < 16; j++)
                if (16 * r + j <= idx) w[(15 - j) * BW +: BW] = m_buf[16 * r + j];
            exp_q.push_back(w);
        end
    endtask

    task automatic check_burst(input string name, input bit hold);
        int k = 0;
        int low = 0;
        int extra = 0;
        bit seen = 0;
        bit rdy = 0;
        logic [RW-1:0] e;
        while (k < 700) begin
            @(negedge clk);
            k++;
            if (o_ready !== 1'b1) low++;
            i_valid = hold; i_data = BW'(2047); i_last = 1'b0;
            if (o_enable === 1'b1) begin seen = 1; break; end
        end
        total++;
        if (!seen || k != 2) begin
            bad++;
            $display("FAIL %s_latency got=%0d required=2 seen=%0d", name, k, seen);
        end
        if (!seen) begin
            exp_q.delete();
            return;
        end
        first_en_cyc = cyc;
        for (int r = 0; r < 16; r++) begin
            if (r > 0) begin
                @(negedge clk);
                if (o_ready !== 1'b1) low++;
            end
            e = exp_q.pop_front();
            total++;
            if (o_enable !== 1'b1 || o_data !== e || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL %s_row%0d got en=%b busy=%b data=%h required en=1 busy=1 data=%h",
                         name, r, o_enable, o_busy, o_data, e);
            end
        end
        last_en_cyc = cyc;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (o_enable !== 1'b0) extra++;
            if (o_ready === 1'b1) begin
                rdy = 1;
                i_valid = 1'b0;
                break;
            end
            low++;
        end
        total++;
        if (!rdy || extra != 0 || low != 32) begin
            bad++;
            $display("FAIL %s_guard got ready_low=%0d extra_en=%0d rose=%0d required 32 0 1",
                     name, low, extra, rdy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0;
        repeat (3) @(negedge clk);
        total += 4;
        if (o_enable !== 1'b0) begin bad++; $display("FAIL rst_enable got=%b required=0", o_enable); end
        if (o_data !== '0) begin bad++; $display("FAIL rst_data got=%h required=0", o_data); end
        if (o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b required=0", o_ready); end
        if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", o_busy); end
        rst = 1'b0;
        @(negedge clk);
        total += 2;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b required=1", o_ready); end
        if (o_busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b required=0", o_busy); end
    endtask

    task automatic test_continuous();
        send_frame(-1, 1'b0, -1);
        check_burst("cont", 1'b0);
    endtask

    task automatic test_toggle();
        send_frame(-1, 1'b1, -1);
        check_burst("toggle", 1'b0);
    endtask

    task automatic test_hold();
        send_frame(-1, 1'b0, -1);
        check_burst("hold", 1'b1);
        send_frame(-1, 1'b0, -1);
        check_burst("after_hold", 1'b0);
    endtask

    task automatic test_reset_mid_send();
        int k = 0;
        int en = 0;
        bit seen = 0;
        logic [RW-1:0] e;
        send_frame(-1, 1'b0, -1);
        while (k < 700) begin
            @(negedge clk);
            k++;
            i_valid = 1'b0;
            if (o_enable === 1'b1) begin seen = 1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL midrst_wait got=none required=enable");
        end
        for (int r = 0; r < 4 && seen; r++) begin
            if (r > 0) @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (o_enable !== 1'b1 || o_data !== e) begin
                bad++;
                $display("FAIL midrst_row%0d got en=%b data=%h required en=1 data=%h", r, o_enable, o_data, e);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (o_enable !== 1'b0 || o_data !== '0) begin
            bad++;
            $display("FAIL midrst_clear got en=%b data=%h required en=0 data=0", o_enable, o_data);
        end
        rst = 1'b0;
        exp_q.delete();
        repeat (20) begin
            @(negedge clk);
            if (o_enable !== 1'b0) en++;
        end
        total++;
        if (en != 0) begin bad++; $display("FAIL midrst_no_rows got=%0d required=0", en); end
        send_frame(341, 1'b0, -1);
        check_burst("fresh155", 1'b0);
    endtask

    task automatic test_back_to_back();
        int gap;
        send_frame(2047, 1'b0, -1);
        check_burst("b2b_7ff", 1'b0);
        gap = last_en_cyc;
        send_frame(1, 1'b0, -1);
        check_burst("b2b_001", 1'b0);
        gap = first_en_cyc - gap;
        total++;
        if (gap < 272) begin bad++; $display("FAIL b2b_gap got=%0d required>=272", gap); end
    endtask

`ifdef TPFEED_PAD_EN
    task automatic test_pad();
        send_frame(2047, 1'b0, -1);
        check_burst("pad_pre", 1'b0);
        send_frame(3, 1'b0, 19);
        check_burst("pad", 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_continuous();
        test_toggle();
        test_hold();
        test_reset_mid_send();
        test_back_to_back();
`ifdef TPFEED_PAD_EN
        test_pad();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
